// File: rtl/control_signals_pkg.sv
// control_signals: shared control-unit types and instruction encodings
package control_signals;
  typedef enum logic [0:0] {ALU_SRC_REG, ALU_SRC_IMM} Alu_Src_t;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_ADD, OP_SUB} Alu_Operation_t;
  typedef enum logic [0:0] {REG_SRC_ALU, REG_SRC_MEM} Reg_Data_Src_t;
  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_TRAP} PC_Src_t;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} Ctrl_State_t;
  typedef enum logic [1:0] {NONE, ILLEGAL, TIMEOUT} Trap_Cause_t;
  typedef enum logic [2:0] {CLS_ALU, CLS_LD, CLS_SD, CLS_BEQ, CLS_BNE, CLS_ILLEGAL} Instr_Class_t;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
endpackage

// File: rtl/multicycle_control_unit_instr_decoder.sv
// instr_decoder: combinational instruction classifier producing ALU controls and illegal flag
module instr_decoder
  import control_signals::*;
#(
  parameter bit BNE_EN = 1'b1
) (
  input  logic [31:0]    instr,
  output Instr_Class_t   cls,
  output Alu_Operation_t alu_op,
  output Alu_Src_t       alu_src,
  output logic           illegal
);
  logic [6:0] op;
  logic [6:0] f7;
  logic [2:0] f3;
  logic unused_bits;
  always_comb begin
    op = instr[6:0];
    f3 = instr[14:12];
    f7 = instr[31:25];
    unused_bits = ^{instr[24:15], instr[11:7]};
    cls = CLS_ILLEGAL;
    alu_op = OP_ADD;
    alu_src = ALU_SRC_REG;
    case (op)
      OPC_LOAD: begin
        cls = f3 == F3_D ? CLS_LD : CLS_ILLEGAL;
        alu_src = ALU_SRC_IMM;
      end
      OPC_STORE: begin
        cls = f3 == F3_D ? CLS_SD : CLS_ILLEGAL;
        alu_src = ALU_SRC_IMM;
      end
      OPC_RTYPE: begin
        alu_op = f3 == F3_AND ? OP_AND : f3 == F3_OR ? OP_OR : f7 == F7_SUB ? OP_SUB : OP_ADD;
        cls = ((f7 == F7_BASE && (f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR)) ||
               (f7 == F7_SUB && f3 == F3_ADD)) ? CLS_ALU : CLS_ILLEGAL;
      end
      OPC_IALU: begin
        alu_src = ALU_SRC_IMM;
        alu_op = f3 == F3_AND ? OP_AND : f3 == F3_OR ? OP_OR : OP_ADD;
        cls = (f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR) ? CLS_ALU : CLS_ILLEGAL;
      end
      OPC_BRANCH: begin
        alu_op = OP_SUB;
        cls = f3 == F3_BEQ ? CLS_BEQ : (f3 == F3_BNE && BNE_EN) ? CLS_BNE : CLS_ILLEGAL;
      end
      default: cls = CLS_ILLEGAL;
    endcase
    illegal = cls == CLS_ILLEGAL;
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multi-cycle sequencing FSM with memory handshakes, traps and retire counter
module multicycle_control_unit
  import control_signals::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32,
  parameter bit BNE_EN      = 1'b1
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic [31:0]         instr_in,
  input  logic                imem_ready_in,
  input  logic                dmem_ready_in,
  input  logic                alu_zero_in,
  output logic                imem_req,
  output logic                dmem_req,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output PC_Src_t             pc_src,
  output Alu_Src_t            alu_src_mux,
  output Alu_Operation_t      alu_op,
  output logic                reg_write,
  output Reg_Data_Src_t       data_ALU_SRC_REG,
  output logic                illegal_instr,
  output logic                mem_timeout,
  output Ctrl_State_t         state_out,
  output logic [RETIRE_W-1:0] retired_count
);
  Ctrl_State_t state;
  Ctrl_State_t nxt;
  Trap_Cause_t cause;
  logic [15:0] wait_cnt;
  Instr_Class_t cls;
  Alu_Operation_t dec_op;
  Alu_Src_t dec_src;
  logic illegal;
  logic in_fetch, in_mem, in_ex, in_wb, in_trap, is_br, is_mem, taken, timeout, retire, alu_live;
  instr_decoder #(.BNE_EN(BNE_EN)) u_dec (
    .instr(instr_in),
    .cls(cls),
    .alu_op(dec_op),
    .alu_src(dec_src),
    .illegal(illegal)
  );
  always_comb begin
    in_fetch = state == FETCH;
    in_mem = state == MEM;
    in_ex = state == EXECUTE;
    in_wb = state == WRITEBACK;
    in_trap = state == TRAP;
    is_br = cls == CLS_BEQ || cls == CLS_BNE;
    is_mem = cls == CLS_LD || cls == CLS_SD;
    taken = cls == CLS_BNE ? !alu_zero_in : alu_zero_in;
    timeout = MEM_TIMEOUT > 0 && wait_cnt == 16'(MEM_TIMEOUT - 1) &&
              ((in_fetch && !imem_ready_in) || (in_mem && !dmem_ready_in));
    nxt = in_fetch ? (imem_ready_in ? DECODE : timeout ? TRAP : FETCH) :
          state == DECODE ? (illegal ? TRAP : EXECUTE) :
          in_ex ? (is_br ? FETCH : is_mem ? MEM : WRITEBACK) :
          in_mem ? (dmem_ready_in ? (cls == CLS_LD ? WRITEBACK : FETCH) : timeout ? TRAP : MEM) :
          FETCH;
    retire = !reset_in && ((in_ex && is_br) || (in_mem && dmem_ready_in && cls == CLS_SD) || in_wb);
    alu_live = !reset_in && (in_ex || in_mem);
    imem_req = !reset_in && in_fetch;
    dmem_req = !reset_in && in_mem;
    mem_write = dmem_req && cls == CLS_SD;
    ir_write = imem_req && imem_ready_in;
    pc_write = !reset_in && ((in_fetch && imem_ready_in) || (in_ex && is_br && taken) || in_trap);
    pc_src = reset_in ? PC_PLUS4 : in_trap ? PC_TRAP : (in_ex && is_br) ? PC_BRANCH : PC_PLUS4;
    alu_op = alu_live ? dec_op : OP_AND;
    alu_src_mux = alu_live ? dec_src : ALU_SRC_REG;
    reg_write = !reset_in && in_wb && instr_in[11:7] != 5'd0;
    data_ALU_SRC_REG = (!reset_in && in_wb && cls == CLS_LD) ? REG_SRC_MEM : REG_SRC_ALU;
    illegal_instr = !reset_in && in_trap && cause == ILLEGAL;
    mem_timeout = !reset_in && in_trap && cause == TIMEOUT;
    state_out = state;
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state <= FETCH;
      wait_cnt <= '0;
      cause <= NONE;
      retired_count <= '0;
    end else begin
      state <= nxt;
      wait_cnt <= nxt == state ? wait_cnt + 16'd1 : '0;
      cause <= (nxt == TRAP && !in_trap) ? (state == DECODE ? ILLEGAL : TIMEOUT) : in_trap ? NONE : cause;
      retired_count <= retired_count + RETIRE_W'(retire);
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized schedule-model bench for multicycle_control_unit
module tb_multicycle_control_unit;
  import control_signals::*;
  localparam int TO = 16;
  localparam int RW = 4;
  localparam int K_ALU = 0, K_LD = 1, K_SD = 2, K_BEQ = 3, K_BNE = 4, K_ILL = 5;
  typedef struct packed {
    Ctrl_State_t st;
    logic imem, dmem, mw, irw, pcw;
    PC_Src_t pcs;
    Alu_Operation_t op;
    Alu_Src_t src;
    logic rw;
    Reg_Data_Src_t ds;
    logic ill, to, ret;
  } exp_t;
  logic clk_in = 1'b0, reset_in = 1'b1, imem_ready_in = 1'b0, dmem_ready_in = 1'b0, alu_zero_in = 1'b0;
  logic [31:0] instr_in = '0;
  logic imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write, illegal_instr, mem_timeout;
  PC_Src_t pc_src;
  Alu_Src_t alu_src_mux;
  Alu_Operation_t alu_op;
  Reg_Data_Src_t data_ALU_SRC_REG;
  Ctrl_State_t state_out;
  logic [RW-1:0] retired_count;
  int errors = 0, checks = 0, mcount = 0, ncyc = 0, abort_at = -1;
  always #5 clk_in = ~clk_in;
  multicycle_control_unit #(.MEM_TIMEOUT(TO), .RETIRE_W(RW), .BNE_EN(1'b1)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .instr_in(instr_in),
    .imem_ready_in(imem_ready_in), .dmem_ready_in(dmem_ready_in), .alu_zero_in(alu_zero_in),
    .imem_req(imem_req), .dmem_req(dmem_req), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_mux(alu_src_mux), .alu_op(alu_op),
    .reg_write(reg_write), .data_ALU_SRC_REG(data_ALU_SRC_REG), .illegal_instr(illegal_instr),
    .mem_timeout(mem_timeout), .state_out(state_out), .retired_count(retired_count)
  );
  function automatic exp_t idle(input Ctrl_State_t s);
    exp_t e;
    e = '0;
    e.st = s;
    e.pcs = PC_PLUS4;
    e.op = OP_AND;
    e.src = ALU_SRC_REG;
    e.ds = REG_SRC_ALU;
    return e;
  endfunction
  function automatic exp_t sample(input logic r);
    return '{state_out, imem_req, dmem_req, mem_write, ir_write, pc_write, pc_src, alu_op,
             alu_src_mux, reg_write, data_ALU_SRC_REG, illegal_instr, mem_timeout, r};
  endfunction
  function automatic void classify(input logic [31:0] i, output int k, output Alu_Operation_t op, output Alu_Src_t src);
    logic [9:0] fr;
    logic [2:0] f3;
    fr = {i[31:25], i[14:12]};
    f3 = i[14:12];
    k = K_ILL;
    op = OP_ADD;
    src = ALU_SRC_IMM;
    if (i[6:0] == 7'h03 && f3 == 3'd3) k = K_LD;
    else if (i[6:0] == 7'h23 && f3 == 3'd3) k = K_SD;
    else if (i[6:0] == 7'h13 && f3 inside {3'd0, 3'd6, 3'd7}) begin
      k = K_ALU;
      op = f3 == 3'd0 ? OP_ADD : f3 == 3'd7 ? OP_AND : OP_OR;
    end else if (i[6:0] == 7'h33 && fr inside {10'h000, 10'h100, 10'h007, 10'h006}) begin
      k = K_ALU;
      src = ALU_SRC_REG;
      op = fr == 10'h100 ? OP_SUB : fr == 10'h007 ? OP_AND : fr == 10'h006 ? OP_OR : OP_ADD;
    end else if (i[6:0] == 7'h63 && f3 inside {3'd0, 3'd1}) begin
      k = f3 == 3'd0 ? K_BEQ : K_BNE;
      op = OP_SUB;
      src = ALU_SRC_REG;
    end
  endfunction
  task automatic chk_vec(input string nm, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, a, e);
    end
  endtask
  task automatic chk_int(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, a, e);
    end
  endtask
  task automatic step(input string nm, input logic ri, input logic rd, input exp_t e_in, output logic ab);
    exp_t e;
    ab = ncyc == abort_at;
    e = ab ? idle(e_in.st) : e_in;
    reset_in = ab;
    imem_ready_in = ri;
    dmem_ready_in = rd;
    @(negedge clk_in);
    chk_vec(nm, sample(e.ret), e);
    chk_int({nm, "_count"}, int'(retired_count), mcount % (1 << RW));
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    imem_ready_in = 1'b0;
    dmem_ready_in = 1'b0;
    mcount = ab ? 0 : mcount + int'(e.ret);
    ncyc++;
  endtask
  task automatic trap(input logic ill);
    exp_t e;
    logic ab;
    e = idle(TRAP);
    e.pcw = 1'b1;
    e.pcs = PC_TRAP;
    e.ill = ill;
    e.to = !ill;
    step("trap", 1'b0, 1'b0, e, ab);
  endtask
  task automatic run_instr(input logic [31:0] ins, input int fw, input int dw, input logic z);
    int k;
    Alu_Operation_t op;
    Alu_Src_t src;
    exp_t e;
    logic ab, rdy;
    classify(ins, k, op, src);
    instr_in = ins;
    alu_zero_in = z;
    ncyc = 0;
    rdy = 1'b0;
    for (int i = 0; i < TO; i++) begin
      rdy = i == fw;
      e = idle(FETCH);
      e.imem = 1'b1;
      e.irw = rdy;
      e.pcw = rdy;
      step("fetch", rdy, 1'b0, e, ab);
      if (ab) return;
      if (rdy) break;
    end
    if (!rdy) begin
      trap(1'b0);
      return;
    end
    step("decode", 1'b0, 1'b0, idle(DECODE), ab);
    if (ab) return;
    if (k == K_ILL) begin
      trap(1'b1);
      return;
    end
    e = idle(EXECUTE);
    e.op = op;
    e.src = src;
    if (k == K_BEQ || k == K_BNE) begin
      e.pcw = k == K_BEQ ? z : !z;
      e.pcs = PC_BRANCH;
      e.ret = 1'b1;
    end
    step("execute", 1'b0, 1'b0, e, ab);
    if (ab || k == K_BEQ || k == K_BNE) return;
    if (k == K_LD || k == K_SD) begin
      rdy = 1'b0;
      for (int i = 0; i < TO; i++) begin
        rdy = i == dw;
        e = idle(MEM);
        e.dmem = 1'b1;
        e.mw = k == K_SD;
        e.op = op;
        e.src = src;
        e.ret = rdy && k == K_SD;
        step("mem", 1'b0, rdy, e, ab);
        if (ab) return;
        if (rdy) break;
      end
      if (!rdy) begin
        trap(1'b0);
        return;
      end
      if (k == K_SD) return;
    end
    e = idle(WRITEBACK);
    e.rw = ins[11:7] != 5'd0;
    e.ds = k == K_LD ? REG_SRC_MEM : REG_SRC_ALU;
    e.ret = 1'b1;
    step("writeback", 1'b0, 1'b0, e, ab);
  endtask
  initial begin
    logic [31:0] ins;
    logic [9:0] rt [4];
    int r, fw, dw;
    rt = '{10'h000, 10'h100, 10'h007, 10'h006};
    repeat (2) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    chk_vec("reset", sample(1'b0), idle(FETCH));
    chk_int("reset_count", int'(retired_count), 0);
    @(posedge clk_in);
    #1;
    reset_in = 1'b0;
    run_instr(32'h002081B3, 0, 0, 1'b0);
    chk_int("add_cycles", ncyc, 4);
    chk_int("add_retired", int'(retired_count), 1);
    run_instr(32'h0000B283, 0, 3, 1'b0);
    chk_int("ld_cycles", ncyc, 8);
    run_instr(32'h00209463, 0, 0, 1'b0);
    chk_int("bne_cycles", ncyc, 3);
    run_instr(32'h00208463, 0, 0, 1'b0);
    chk_int("beq_cycles", ncyc, 3);
    chk_int("branch_retired", int'(retired_count), 4);
    run_instr(32'h0000007F, 0, 0, 1'b0);
    chk_int("illegal_cycles", ncyc, 3);
    chk_int("illegal_retired", int'(retired_count), 4);
    run_instr(32'h00508013, 0, 0, 1'b0);
    chk_int("addi_x0_cycles", ncyc, 4);
    run_instr(32'h0020B023, 0, 20, 1'b0);
    chk_int("sd_timeout_cycles", ncyc, 20);
    chk_int("sd_timeout_retired", int'(retired_count), 5);
    run_instr(32'h0020B023, 0, 15, 1'b0);
    chk_int("sd_late_ready_cycles", ncyc, 19);
    chk_int("sd_late_ready_retired", int'(retired_count), 6);
    run_instr(32'h002081B3, 16, 0, 1'b0);
    chk_int("fetch_timeout_cycles", ncyc, 17);
    run_instr(32'h002081B3, 15, 0, 1'b0);
    chk_int("fetch_late_ready_cycles", ncyc, 19);
    chk_int("fetch_late_retired", int'(retired_count), 7);
    abort_at = 4;
    run_instr(32'h0000B283, 0, 10, 1'b0);
    abort_at = -1;
    chk_int("abort_cycles", ncyc, 5);
    chk_int("abort_count", int'(retired_count), 0);
    repeat (15) run_instr(32'h002081B3, 0, 0, 1'b0);
    chk_int("count_15", int'(retired_count), 15);
    run_instr(32'h002081B3, 0, 0, 1'b0);
    chk_int("count_wrap", int'(retired_count), 0);
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      r = $urandom_range(0, 9);
      case (r)
        0: begin ins[6:0] = 7'h03; ins[14:12] = 3'd3; end
        1: begin ins[6:0] = 7'h23; ins[14:12] = 3'd3; end
        2, 3: begin ins[6:0] = 7'h33; {ins[31:25], ins[14:12]} = rt[$urandom_range(0, 3)]; end
        4: begin ins[6:0] = 7'h13; ins[14:12] = 3'($urandom_range(0, 7)); end
        5: begin ins[6:0] = 7'h63; ins[14:12] = 3'($urandom_range(0, 1)); end
        6: ins[1:0] = 2'b11;
        7: ins[6:0] = 7'h33;
        8: ins[6:0] = 7'h63;
        default: begin ins[6:0] = 7'h13; ins[14:12] = 3'd0; ins[11:7] = 5'd0; end
      endcase
      fw = $urandom_range(0, 19) == 0 ? $urandom_range(14, 17) : $urandom_range(0, 3);
      dw = $urandom_range(0, 19) == 0 ? $urandom_range(14, 17) : $urandom_range(0, 3);
      run_instr(ins, fw, dw, 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
